// File: rtl/sensor_trace_pkg.sv
// Shared definitions for the sensor trace capture block.
//   trace_state_t   : controller states
//   MARKER_DEFAULT  : byte stored in every channel while marker_in is high
//   HEADER_SYNC     : first byte of the optional readout header
//   HEADER_BYTES    : length of the optional readout header
package sensor_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE,
        READOUT
    } trace_state_t;

    localparam logic [7:0]  MARKER_DEFAULT = 8'hFF;
    localparam logic [7:0]  HEADER_SYNC    = 8'hA5;
    localparam int unsigned HEADER_BYTES   = 4;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port, single-clock trace memory with synchronous read
// (one cycle latency, unregistered address), suitable for block RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled on the clock edge
//   rdata : read data, valid the cycle after raddr is presented
module trace_ram #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sensor_trace_capture.sv
// Multi-channel sensor trace capture and byte-serial readout.
// On trig, stores one word (CH_COUNT bytes, or all-MARKER while marker_in
// is high) every cfg_decim+1 cycles into the trace RAM until cfg_len words
// (DEPTH when 0 or too large) are captured. On rd_start from DONE, streams
// the trace over tx_data/tx_valid/tx_ready, word 0 ch0 first.
// Optional build macro TRACE_HEADER_EN: prefix the readout with
// A5, CH_COUNT, cap_count[15:8], cap_count[7:0].
//   clk, rst            : clock, synchronous active-high reset
//   sample_in/marker_in : channel bytes (ch0 in [7:0]) and marker flag
//   trig, cfg_len, cfg_decim : capture start and configuration
//   rd_start            : readout start
//   tx_data/valid/ready : readout byte stream
//   busy, cap_done, rd_done, cap_count : status
module sensor_trace_capture
    import sensor_trace_pkg::*;
#(
    parameter int unsigned CH_COUNT = 1,
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter logic [7:0]  MARKER   = MARKER_DEFAULT,
    parameter int unsigned DECIM_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*CH_COUNT-1:0] sample_in,
    input  logic                  marker_in,
    input  logic                  trig,
    input  logic [ADDR_W:0]       cfg_len,
    input  logic [DECIM_W-1:0]    cfg_decim,
    input  logic                  rd_start,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  cap_done,
    output logic                  rd_done,
    output logic [ADDR_W:0]       cap_count
);

    localparam int unsigned     W        = 8 * CH_COUNT;
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE      = 1;
    localparam logic [1:0]      LAST_CH  = 2'(CH_COUNT - 1);

    trace_state_t state, state_n;

    logic [ADDR_W:0]    len_q, wcnt, fptr, fptr_n, eff_len;
    logic [DECIM_W-1:0] decim_q, dcnt;
    logic [W-1:0]       cur_q, ram_wdata, ram_rdata;
    logic [1:0]         chi;
    logic               prime;
    logic               wr_en, cap_last, advance, hdr_more, byte_more;
    logic               word_more, load, rd_last;

    assign eff_len   = (cfg_len == '0 || cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
    assign ram_wdata = marker_in ? {CH_COUNT{MARKER}} : sample_in;
    assign wr_en     = (state == CAPTURE) && (dcnt == '0);
    assign cap_last  = wr_en && ((wcnt + ONE) == len_q);

    // prime blocks the first READOUT cycle so the RAM output for word 0
    // settles; tx_valid therefore rises two cycles after rd_start.
    assign advance   = (state == READOUT) && !prime && (!tx_valid || tx_ready);
    assign byte_more = (chi != LAST_CH);
    assign word_more = (fptr < cap_count);
    assign load      = advance && !hdr_more && !byte_more && word_more;
    assign rd_last   = advance && !hdr_more && !byte_more && !word_more;

    // Read address is the next pointer value, so the RAM output always
    // holds the word at fptr: the prefetch for back-to-back transfers.
    assign fptr_n    = load ? fptr + ONE : fptr;

`ifdef TRACE_HEADER_EN
    logic [2:0]  hcnt;
    logic [7:0]  hdr_byte;
    logic [15:0] cc16;

    assign cc16     = 16'(cap_count);
    assign hdr_more = (hcnt != 3'(HEADER_BYTES));

    always_comb begin
        hdr_byte = cc16[7:0];
        case (hcnt)
            3'd0:    hdr_byte = HEADER_SYNC;
            3'd1:    hdr_byte = 8'(CH_COUNT);
            3'd2:    hdr_byte = cc16[15:8];
            default: hdr_byte = cc16[7:0];
        endcase
    end
`else
    assign hdr_more = 1'b0;
`endif

    trace_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .WIDTH (W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wcnt[ADDR_W-1:0]),
        .wdata(ram_wdata),
        .raddr(fptr_n[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trig) state_n = CAPTURE;
            CAPTURE: if (cap_last) state_n = DONE;
            DONE: begin
                if (trig)          state_n = CAPTURE;
                else if (rd_start) state_n = READOUT;
            end
            READOUT: if (rd_last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CAPTURE) || (state == READOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            cap_done  <= 1'b0;
            rd_done   <= 1'b0;
            cap_count <= '0;
            len_q     <= '0;
            decim_q   <= '0;
            dcnt      <= '0;
            wcnt      <= '0;
            fptr      <= '0;
            cur_q     <= '0;
            chi       <= '0;
            prime     <= 1'b0;
`ifdef TRACE_HEADER_EN
            hcnt      <= '0;
`endif
        end else begin
            cap_done <= 1'b0;
            rd_done  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (trig) begin
                        len_q   <= eff_len;
                        decim_q <= cfg_decim;
                        dcnt    <= '0;
                        wcnt    <= '0;
                    end else if (rd_start && state == DONE) begin
                        fptr  <= '0;
                        chi   <= LAST_CH;
                        prime <= 1'b1;
`ifdef TRACE_HEADER_EN
                        hcnt  <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    dcnt <= (dcnt == decim_q) ? '0 : dcnt + DECIM_W'(1);
                    if (wr_en) wcnt <= wcnt + ONE;
                    if (cap_last) begin
                        cap_count <= len_q;
                        cap_done  <= 1'b1;
                    end
                end
                READOUT: begin
                    prime <= 1'b0;
                    if (advance) begin
                        if (hdr_more) begin
`ifdef TRACE_HEADER_EN
                            tx_data  <= hdr_byte;
                            tx_valid <= 1'b1;
                            hcnt     <= hcnt + 3'd1;
`endif
                        end else if (byte_more) begin
                            tx_data  <= cur_q[7:0];
                            cur_q    <= cur_q >> 8;
                            chi      <= chi + 2'd1;
                            tx_valid <= 1'b1;
                        end else if (word_more) begin
                            tx_data  <= ram_rdata[7:0];
                            cur_q    <= ram_rdata >> 8;
                            chi      <= '0;
                            fptr     <= fptr_n;
                            tx_valid <= 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                            rd_done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
